// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding and parameter sanity helpers for mux_n_reg_pipe
package mux_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
    function automatic bit cfg_ok(input int n_in, input int sel_w, input int def_idx);
        return n_in >= 2 && n_in <= 16 && sel_w >= clog2(n_in) && def_idx >= 0 && def_idx < n_in;
    endfunction
endpackage

// File: rtl/mux_n_sel.sv
// mux_n_sel: combinational N:1 selector, out-of-range selects fall back to DEFAULT_IDX and raise o_erro
module mux_n_sel #(
    parameter int WIDTH       = 5,
    parameter int N_IN        = 4,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_IDX = 0
) (
    input  logic [N_IN*WIDTH-1:0] i_entradas,
    input  logic [SEL_W-1:0]      i_controle,
    output logic [WIDTH-1:0]      o_dado,
    output logic                  o_erro
);
    int w_idx;
    assign o_erro = int'(i_controle) >= N_IN;
    assign w_idx  = o_erro ? DEFAULT_IDX : int'(i_controle);
    always_comb begin
        o_dado = '0;
        for (int i = 0; i < N_IN; i++) if (i == w_idx) o_dado = i_entradas[i*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/mux_n_reg_pipe.sv
// mux_n_reg_pipe: N:1 selector feeding a 2-entry registered skid buffer with valid/ready on both sides
module mux_n_reg_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int N_IN        = 4,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_IDX = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] entradas,
    input  logic [SEL_W-1:0]      controle,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      saida,
    output logic                  sel_erro,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            nivel
);
    if (!cfg_ok(N_IN, SEL_W, DEFAULT_IDX)) begin : g_bad_cfg
        $error("mux_n_reg_pipe: illegal N_IN/SEL_W/DEFAULT_IDX combination");
    end
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_head_d, r_skid_d, w_dado;
    logic             r_head_e, r_skid_e, w_erro;
    logic             w_in_fire, w_out_fire;
    mux_n_sel #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .DEFAULT_IDX(DEFAULT_IDX)) u_sel (
        .i_entradas(entradas),
        .i_controle(controle),
        .o_dado    (w_dado),
        .o_erro    (w_erro)
    );
    assign in_ready   = (r_state != FULL) && !reset;
    assign out_valid  = r_state != EMPTY;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign saida      = r_head_d;
    assign sel_erro   = r_head_e;
    assign nivel      = r_state;
    always_comb begin
        w_next = r_state == EMPTY ? (w_in_fire ? ONE : EMPTY) :
                 r_state == ONE   ? (w_in_fire && !w_out_fire ? FULL : !w_in_fire && w_out_fire ? EMPTY : ONE) :
                                    (w_out_fire ? ONE : FULL);
    end
    // head loads a new beat only when it is empty or being drained in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_head_d <= '0;
            r_head_e <= 1'b0;
            r_skid_d <= '0;
            r_skid_e <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_fire && (r_state == EMPTY || w_out_fire)) begin
                r_head_d <= w_dado;
                r_head_e <= w_erro;
            end
            if (w_in_fire && r_state == ONE && !w_out_fire) begin
                r_skid_d <= w_dado;
                r_skid_e <= w_erro;
            end
            if (r_state == FULL && w_out_fire) begin
                r_head_d <= r_skid_d;
                r_head_e <= r_skid_e;
            end
        end
    end
endmodule

// File: tb/tb_mux_n_reg_pipe.sv
// tb_mux_n_reg_pipe: scoreboard bench, driver pushes reference beats, monitor pops on out_fire
module tb_mux_n_reg_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    logic [19:0] ent_a;
    logic [1:0]  ctl_a, nv_a;
    logic        iv_a, ir_a, ov_a, or_a, er_a;
    logic [4:0]  sd_a;
    logic [14:0] ent_b;
    logic [1:0]  ctl_b, nv_b;
    logic        iv_b, ir_b, ov_b, or_b, er_b;
    logic [4:0]  sd_b;
    int checks = 0;
    int errors = 0;
    logic [5:0] qa[$];
    logic [5:0] qb[$];
    logic [5:0] e_a, e_b;
    logic       stall_a = 1'b0;
    logic [4:0] prev_a;
    bit         pend;

    mux_n_reg_pipe u_a (
        .clock(clock), .reset(reset), .entradas(ent_a), .controle(ctl_a),
        .in_valid(iv_a), .in_ready(ir_a), .saida(sd_a), .sel_erro(er_a),
        .out_valid(ov_a), .out_ready(or_a), .nivel(nv_a)
    );
    mux_n_reg_pipe #(.WIDTH(5), .N_IN(3), .SEL_W(2), .DEFAULT_IDX(1)) u_b (
        .clock(clock), .reset(reset), .entradas(ent_b), .controle(ctl_b),
        .in_valid(iv_b), .in_ready(ir_b), .saida(sd_b), .sel_erro(er_b),
        .out_valid(ov_b), .out_ready(or_b), .nivel(nv_b)
    );

    function automatic logic [5:0] ref_beat(input logic [79:0] ent, input int n_in, input int def, input int c);
        int idx;
        logic [79:0] sh;
        idx = (c < n_in) ? c : def;
        sh  = ent >> (idx * 5);
        return {c >= n_in, sh[4:0]};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic [1:0] c, input logic ordy);
        @(negedge clock);
        iv_a = v;
        ctl_a = c;
        or_a = ordy;
        #1;
        if (iv_a && ir_a) qa.push_back(ref_beat(80'(ent_a), 4, 0, int'(ctl_a)));
    endtask

    task automatic step_b(input logic v, input logic [1:0] c);
        @(negedge clock);
        iv_b = v;
        ctl_b = c;
        #1;
        if (iv_b && ir_b) qb.push_back(ref_beat(80'(ent_b), 3, 1, int'(ctl_b)));
    endtask

    always @(negedge clock) begin
        #2;
        if (stall_a && ov_a) chk("hold_a", int'(sd_a), int'(prev_a));
        stall_a = ov_a && !or_a;
        prev_a = sd_a;
        if (ov_a && or_a) begin
            if (qa.size() == 0) chk("unexpected_beat_a", 0, 1);
            else begin
                e_a = qa.pop_front();
                chk("data_a", int'(sd_a), int'(e_a[4:0]));
                chk("err_a", int'(er_a), int'(e_a[5]));
            end
        end
        if (ov_b && or_b) begin
            if (qb.size() == 0) chk("unexpected_beat_b", 0, 1);
            else begin
                e_b = qb.pop_front();
                chk("data_b", int'(sd_b), int'(e_b[4:0]));
                chk("err_b", int'(er_b), int'(e_b[5]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        iv_a = 0; ctl_a = 0; or_a = 0; ent_a = '0;
        iv_b = 0; ctl_b = 0; or_b = 1; ent_b = '0;
        repeat (3) @(negedge clock);
        reset = 0;
        #1;
        chk("rst_ov", int'(ov_a), 0);
        chk("rst_nivel", int'(nv_a), 0);
        chk("rst_saida", int'(sd_a), 0);
        chk("rst_ir", int'(ir_a), 1);

        ent_a = {5'd3, 5'd2, 5'd1, 5'd0};
        for (int i = 0; i < 4; i++) begin
            step_a(1, 2'(i), 1);
            if (i > 0) begin
                chk("t1_nivel", int'(nv_a), 1);
                chk("t1_ov", int'(ov_a), 1);
                chk("t1_lat", int'(sd_a), i - 1);
            end
        end
        step_a(0, 0, 1);
        chk("t1_last", int'(sd_a), 3);
        chk("t1_nivel_last", int'(nv_a), 1);
        step_a(0, 0, 1);
        chk("t1_empty_ov", int'(ov_a), 0);
        chk("t1_keep", int'(sd_a), 3);

        ent_b = {5'd22, 5'd17, 5'd5};
        step_b(1, 3);
        step_b(1, 0);
        chk("t2_default", int'(sd_b), 17);
        chk("t2_err", int'(er_b), 1);
        step_b(0, 0);
        chk("t2_in_range", int'(sd_b), 5);
        chk("t2_noerr", int'(er_b), 0);
        step_b(0, 0);

        ent_a = {5'd11, 5'd10, 5'd9, 5'd0};
        step_a(1, 1, 0);
        step_a(1, 2, 0);
        chk("t3_nivel1", int'(nv_a), 1);
        step_a(1, 3, 0);
        chk("t3_nivel2", int'(nv_a), 2);
        chk("t3_ir_full", int'(ir_a), 0);
        step_a(1, 3, 0);
        chk("t3_hold9", int'(sd_a), 9);
        chk("t3_still_full", int'(nv_a), 2);
        step_a(1, 3, 1);
        chk("t3_out9", int'(sd_a), 9);
        step_a(1, 3, 1);
        chk("t3_out10", int'(sd_a), 10);
        chk("t3_ov10", int'(ov_a), 1);
        step_a(0, 0, 1);
        chk("t3_out11", int'(sd_a), 11);
        chk("t3_ov11", int'(ov_a), 1);
        step_a(0, 0, 1);
        chk("t3_drained", int'(ov_a), 0);

        pend = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock);
            if (!pend) begin
                ent_a = 20'($urandom);
                ctl_a = 2'($urandom);
                iv_a = 1'($urandom);
            end
            or_a = 1'($urandom);
            #1;
            if (iv_a && ir_a) begin
                qa.push_back(ref_beat(80'(ent_a), 4, 0, int'(ctl_a)));
                pend = 0;
            end else pend = iv_a;
        end
        repeat (4) step_a(0, 0, 1);
        chk("t4_drain", qa.size(), 0);

        step_a(1, 1, 0);
        step_a(1, 2, 0);
        step_a(1, 3, 0);
        chk("t5_full", int'(nv_a), 2);
        @(negedge clock);
        reset = 1;
        #1;
        chk("t5_rst_ir", int'(ir_a), 0);
        qa.delete();
        qb.delete();
        @(negedge clock);
        reset = 0;
        iv_a = 0;
        #1;
        chk("t5_ov", int'(ov_a), 0);
        chk("t5_nivel", int'(nv_a), 0);
        chk("t5_saida", int'(sd_a), 0);
        chk("t5_err", int'(er_a), 0);
        chk("t5_ir", int'(ir_a), 1);

        step_a(1, 2, 0);
        step_a(0, 0, 0);
        chk("t6_one", int'(nv_a), 1);
        chk("t6_ir_one", int'(ir_a), 1);
        @(negedge clock);
        reset = 1;
        #1;
        chk("t6_rst_ir", int'(ir_a), 0);
        qa.delete();
        @(negedge clock);
        reset = 0;
        #1;
        chk("t6_nivel", int'(nv_a), 0);
        chk("t6_ov", int'(ov_a), 0);
        chk("t6_ir", int'(ir_a), 1);
        step_a(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_n_reg_pipe.md
Name: mux_n_reg_pipe

Overview:
- Parametrised N:1 selector with a registered output and a valid/ready handshake on both sides; next generation of the 2:1 5-bit register-address mux.
- Selects one of N_IN packed inputs by `controle` and registers the result into a 2-entry skid buffer.
- Flags out-of-range selects per beat.
- Sits between control-unit decode and register-file/ALU operand paths, where the producer and consumer can stall independently.

Parameters:
- WIDTH, 5, bit width of each input and of `saida`.
- N_IN, 4, number of selectable inputs (2..16).
- SEL_W, 2, width of `controle`; must satisfy 2**SEL_W >= N_IN.
- DEFAULT_IDX, 0, input index used when `controle` >= N_IN.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- entradas  in  N_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- controle  in  SEL_W  select index, sampled with `in_valid`.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block can accept a beat.
- saida  out  WIDTH  selected data at the head of the buffer.
- sel_erro  out  1  head beat was selected with an out-of-range `controle`.
- out_valid  out  1  `saida`/`sel_erro` valid.
- out_ready  in  1  consumer takes the head beat.
- nivel  out  2  occupancy: 0, 1 or 2.

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high on `reset`. Reset has priority over all handshake activity.
- Reset values:
  - `saida` = 0, `sel_erro` = 0, `out_valid` = 0, `nivel` = 0.
  - Internal skid register = 0.
  - State = EMPTY.
- While `reset` = 1: `in_ready` = 0. It is combinational from `reset` and state, and rises the cycle after `reset` deasserts.
- Selection is combinational and happens on the accepted beat:
  - Index = `controle` if `controle` < N_IN, else DEFAULT_IDX.
  - The error bit = (`controle` >= N_IN); it is stored with the data.
- Handshake definitions: in_fire = `in_valid` & `in_ready`; out_fire = `out_valid` & `out_ready`.
- `in_valid` may rise without waiting for `in_ready`. The producer must hold `entradas`/`controle` stable until in_fire.
- Latency: a beat accepted at edge k appears on `saida` with `out_valid` = 1 immediately after edge k (1 cycle). Sustained throughput is 1 beat/cycle when `out_ready` = 1.
- States: EMPTY (nivel 0), ONE (nivel 1), FULL (nivel 2). `out_valid` = (state != EMPTY); `in_ready` = (state != FULL) & !reset.
- Transitions:
  - EMPTY: in_fire -> ONE, head <= selected beat. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, head <= new beat.
  - ONE, in_fire & !out_fire -> FULL, skid <= new beat, head unchanged.
  - ONE, !in_fire & out_fire -> EMPTY, head register keeps its last value.
  - ONE, neither -> stay.
  - FULL: no in_fire is possible. out_fire -> ONE, head <= skid. Otherwise stay.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- When EMPTY, `saida`/`sel_erro` keep the last drained value. They are not zeroed, and consumers must qualify them with `out_valid`.
- Reset mid-operation: buffered beats are discarded at the reset edge and all outputs return to reset values the next cycle.
- A change of `out_ready` with `out_valid` = 1 is legal at any time. Head data is stable while `out_valid` = 1 and `out_ready` = 0.

Decomposition:
- Package mux_pkg:
  - 2-bit state encoding EMPTY/ONE/FULL.
  - clog2 function for checking SEL_W against N_IN.
  - Elaboration check that fails if N_IN < 2 or 2**SEL_W < N_IN.
- Sub-module mux_n_sel: purely combinational N:1 selector with range check (outputs data + erro), parametrised by WIDTH, N_IN, SEL_W, DEFAULT_IDX.
- The top level holds the skid buffer and the state machine.

Test Plan:
- Reset then N_IN=4, WIDTH=5, entradas = {5'd3, 5'd2, 5'd1, 5'd0} (input 3 at top, input 0 at bottom), out_ready=1, in_valid=1 with controle 0,1,2,3 on consecutive cycles.
  - Required: saida = 0,1,2,3 one cycle after each acceptance.
  - Required: out_valid held at 1 throughout, nivel = 1 throughout.
- With N_IN=3, SEL_W=2, DEFAULT_IDX=1, input 1 = 5'd17, send one beat with controle = 3.
  - Required: saida = 17 and sel_erro = 1.
  - Required: the following beat with controle = 0 gives sel_erro = 0.
- out_ready=0, send beats A=5'd9, B=5'd10, then offer C=5'd11.
  - Required: nivel goes 1 then 2, and in_ready = 0 after B.
  - Required: C is not accepted and saida stays 9.
  - Then out_ready=1: outputs 9, 10, 11 in order with no gaps.
- Random in_valid/out_ready toggling for 1000 cycles against a reference queue.
  - Required: output sequence equals input sequence, no loss or duplication.
  - Required: saida stable whenever out_valid=1 & out_ready=0.
- Buffer FULL, then assert reset for 1 cycle.
  - Required: during reset, in_ready=0.
  - Required: after reset, out_valid=0, nivel=0, saida=0, sel_erro=0, and in_ready=1 on the first cycle after reset.
